// File: rtl/wb_commit_if.sv
// Retire-slot bundle between the issue/execute pipe and the writeback commit unit.
//   master modport : the pipe side. It drives the master and slave retire slots and sees commit_ready.
//   slave modport  : the commit unit side. It receives both slots and drives commit_ready.
// Slot fields: valid, pc[31:0], wen, wa[4:0], wd[31:0].
// The master slot is the older instruction and the slave slot is the younger one.
interface wb_commit_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_wen;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        s_valid;
  logic [31:0] s_pc;
  logic        s_wen;
  logic [4:0]  s_wa;
  logic [31:0] s_wd;
  logic        commit_ready;

  modport master (
    output m_valid, m_pc, m_wen, m_wa, m_wd,
    output s_valid, s_pc, s_wen, s_wa, s_wd,
    input  commit_ready
  );

  modport slave (
    input  m_valid, m_pc, m_wen, m_wa, m_wd,
    input  s_valid, s_pc, s_wen, s_wa, s_wd,
    output commit_ready
  );
endinterface

// File: rtl/wb_commit_unit.sv
// Dual-issue writeback/commit stage.
// It is the writer end of a 2-write-port register file, and it serialises retired
// instructions into a one-per-cycle debug trace.
//   clk, rst                      : clock, synchronous active-high reset
//   rb (wb_commit_if.slave)       : master/slave retire slots in, commit_ready out
//   wen1/wa1/wd1                  : regfile write port 1 (master), registered
//   wen2/wa2/wd2                  : regfile write port 2 (slave), registered
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata, trace_valid : registered trace output
// The slave slot is younger. On a same-register conflict only the slave write is issued.

// Per-slot accept and write qualification. There is one instance per retire slot.
module wb_commit_lane (
  input  logic       valid,
  input  logic       ready,
  input  logic       wen,
  input  logic [4:0] wa,
  output logic       acc,
  output logic       wr
);
  assign acc = valid && ready;
  // $zero is never written
  assign wr  = acc && wen && (wa != 5'd0);
endmodule

module wb_commit_unit #(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  wb_commit_if.slave  rb,
  output logic        wen1,
  output logic [4:0]  wa1,
  output logic [31:0] wd1,
  output logic        wen2,
  output logic [4:0]  wa2,
  output logic [31:0] wd2,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata,
  output logic        trace_valid
);
  localparam int NUM_LANES = 2;
  localparam int OCC_W     = PTR_W + 1;
  localparam logic [OCC_W-1:0] RDY_MAX = OCC_W'(FIFO_DEPTH - 2);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  wa;
    logic [31:0] wd;
  } trace_ent_t;

  // Lane 0 is the master slot and lane 1 is the slave slot.
  logic [NUM_LANES-1:0]      ln_valid, ln_wen, ln_acc, ln_wr;
  logic [NUM_LANES-1:0][4:0] ln_wa;
  logic                      commit_ready;

  assign ln_valid = {rb.s_valid, rb.m_valid};
  assign ln_wen   = {rb.s_wen, rb.m_wen};
  assign ln_wa    = {rb.s_wa, rb.m_wa};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    wb_commit_lane u_lane (
      .valid (ln_valid[i]),
      .ready (commit_ready),
      .wen   (ln_wen[i]),
      .wa    (ln_wa[i]),
      .acc   (ln_acc[i]),
      .wr    (ln_wr[i])
    );
  end

  trace_ent_t       mem_q [FIFO_DEPTH];
  trace_ent_t       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d, s_idx;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             pop, conflict;
  trace_ent_t       head;

  logic        wen1_q, wen1_d, wen2_q, wen2_d;
  logic [4:0]  wa1_q, wa1_d, wa2_q, wa2_d;
  logic [31:0] wd1_q, wd1_d, wd2_q, wd2_d;
  logic [31:0] dpc_q, dpc_d, dwd_q, dwd_d;
  logic [3:0]  dwen_q, dwen_d;
  logic [4:0]  dwa_q, dwa_d;
  logic        tv_q, tv_d;

  // The ready decision uses only registered occupancy, so it cannot depend on this cycle's pushes.
  // Two free slots guarantee that a dual accept always fits.
  assign commit_ready = !rst && (occ_q <= RDY_MAX);
  assign rb.commit_ready = commit_ready;

  always_comb begin
    mem_d  = mem_q;
    pop    = (occ_q != '0);
    head   = mem_q[rptr_q];
    // When the master is not pushed this cycle, the slave takes the master's slot.
    s_idx  = wptr_q + PTR_W'(ln_acc[0]);
    if (ln_acc[0]) mem_d[wptr_q] = '{rb.m_pc, ln_wr[0], rb.m_wa, rb.m_wd};
    if (ln_acc[1]) mem_d[s_idx]  = '{rb.s_pc, ln_wr[1], rb.s_wa, rb.s_wd};
    wptr_d = s_idx + PTR_W'(ln_acc[1]);
    rptr_d = rptr_q + PTR_W'(pop);
    occ_d  = occ_q + OCC_W'(ln_acc[0]) + OCC_W'(ln_acc[1]) - OCC_W'(pop);

    // The slave is younger, so the master write is dropped on a conflict.
    // The trace still records the master write.
    conflict = ln_wr[0] && ln_wr[1] && (rb.m_wa == rb.s_wa);
    wen1_d   = ln_wr[0] && !conflict;
    wa1_d    = ln_acc[0] ? rb.m_wa : wa1_q;
    wd1_d    = ln_acc[0] ? rb.m_wd : wd1_q;
    wen2_d   = ln_wr[1];
    wa2_d    = ln_acc[1] ? rb.s_wa : wa2_q;
    wd2_d    = ln_acc[1] ? rb.s_wd : wd2_q;

    tv_d   = pop;
    dwen_d = pop ? {4{head.wen}} : 4'h0;
    dpc_d  = pop ? head.pc : dpc_q;
    dwa_d  = pop ? head.wa : dwa_q;
    dwd_d  = pop ? head.wd : dwd_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      occ_q  <= '0;
      wen1_q <= 1'b0;
      wa1_q  <= '0;
      wd1_q  <= '0;
      wen2_q <= 1'b0;
      wa2_q  <= '0;
      wd2_q  <= '0;
      tv_q   <= 1'b0;
      dwen_q <= '0;
      dpc_q  <= '0;
      dwa_q  <= '0;
      dwd_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      wen1_q <= wen1_d;
      wa1_q  <= wa1_d;
      wd1_q  <= wd1_d;
      wen2_q <= wen2_d;
      wa2_q  <= wa2_d;
      wd2_q  <= wd2_d;
      tv_q   <= tv_d;
      dwen_q <= dwen_d;
      dpc_q  <= dpc_d;
      dwa_q  <= dwa_d;
      dwd_q  <= dwd_d;
    end
  end

  // Occupancy above depth would mean the ready threshold is broken.
  always_ff @(posedge clk) begin
    if (!rst) assert (occ_q <= OCC_MAX);
  end

  assign wen1              = wen1_q;
  assign wa1               = wa1_q;
  assign wd1               = wd1_q;
  assign wen2              = wen2_q;
  assign wa2               = wa2_q;
  assign wd2               = wd2_q;
  assign debug_wb_pc       = dpc_q;
  assign debug_wb_rf_wen   = dwen_q;
  assign debug_wb_rf_wnum  = dwa_q;
  assign debug_wb_rf_wdata = dwd_q;
  assign trace_valid       = tv_q;
endmodule

// File: tb/tb_wb_commit_unit.sv
module tb_wb_commit_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        wen1, wen2, trace_valid;
  logic [4:0]  wa1, wa2, debug_wb_rf_wnum;
  logic [31:0] wd1, wd2, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  int          errors = 0;
  int          checks = 0;

  wb_commit_if bus ();

  wb_commit_unit #(.FIFO_DEPTH(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .rb                (bus),
    .wen1              (wen1),
    .wa1               (wa1),
    .wd1               (wd1),
    .wen2              (wen2),
    .wa2               (wa2),
    .wd2               (wd2),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .trace_valid       (trace_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input logic v, input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.m_valid = v; bus.m_pc = pc; bus.m_wen = we; bus.m_wa = wa; bus.m_wd = wd;
  endtask

  task automatic set_s(input logic v, input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
    bus.s_valid = v; bus.s_pc = pc; bus.s_wen = we; bus.s_wa = wa; bus.s_wd = wd;
  endtask

  initial begin
    int occ_m, n, tk, traced;
    logic acc, pop, saw_drop;
    rst = 1'b1;
    set_m(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_s(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    // reset state
    chk("rst_ready", 32'(bus.commit_ready), 32'd0);
    chk("rst_wen1", 32'(wen1), 32'd0);
    chk("rst_wen2", 32'(wen2), 32'd0);
    chk("rst_tv", 32'(trace_valid), 32'd0);
    chk("rst_rfwen", 32'(debug_wb_rf_wen), 32'd0);
    chk("rst_pc", debug_wb_pc, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(bus.commit_ready), 32'd1);

    // 1: dual commit to different registers
    set_m(1'b1, 32'hBFC00000, 1'b1, 5'd3, 32'h11);
    set_s(1'b1, 32'hBFC00004, 1'b1, 5'd4, 32'h22);
    tick();
    set_m(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_s(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t1_wen1", 32'(wen1), 32'd1);
    chk("t1_wa1", 32'(wa1), 32'd3);
    chk("t1_wd1", wd1, 32'h11);
    chk("t1_wen2", 32'(wen2), 32'd1);
    chk("t1_wa2", 32'(wa2), 32'd4);
    chk("t1_wd2", wd2, 32'h22);
    chk("t1_tv0", 32'(trace_valid), 32'd0);
    tick();
    chk("t1_wen1_off", 32'(wen1), 32'd0);
    chk("t1_wen2_off", 32'(wen2), 32'd0);
    chk("t1_tv1", 32'(trace_valid), 32'd1);
    chk("t1_pc1", debug_wb_pc, 32'hBFC00000);
    chk("t1_rfwen1", 32'(debug_wb_rf_wen), 32'hf);
    chk("t1_wnum1", 32'(debug_wb_rf_wnum), 32'd3);
    chk("t1_wdata1", debug_wb_rf_wdata, 32'h11);
    tick();
    chk("t1_tv2", 32'(trace_valid), 32'd1);
    chk("t1_pc2", debug_wb_pc, 32'hBFC00004);
    chk("t1_wnum2", 32'(debug_wb_rf_wnum), 32'd4);
    chk("t1_wdata2", debug_wb_rf_wdata, 32'h22);
    tick();
    chk("t1_empty_tv", 32'(trace_valid), 32'd0);
    chk("t1_empty_rfwen", 32'(debug_wb_rf_wen), 32'd0);
    chk("t1_empty_pchold", debug_wb_pc, 32'hBFC00004);

    // 2: same-register conflict, the slave wins the regfile
    set_m(1'b1, 32'h100, 1'b1, 5'd5, 32'hAA);
    set_s(1'b1, 32'h104, 1'b1, 5'd5, 32'hBB);
    tick();
    set_m(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_s(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t2_wen1", 32'(wen1), 32'd0);
    chk("t2_wen2", 32'(wen2), 32'd1);
    chk("t2_wa2", 32'(wa2), 32'd5);
    chk("t2_wd2", wd2, 32'hBB);
    tick();
    chk("t2_pc1", debug_wb_pc, 32'h100);
    chk("t2_wdata1", debug_wb_rf_wdata, 32'hAA);
    chk("t2_rfwen1", 32'(debug_wb_rf_wen), 32'hf);
    tick();
    chk("t2_pc2", debug_wb_pc, 32'h104);
    chk("t2_wdata2", debug_wb_rf_wdata, 32'hBB);
    chk("t2_rfwen2", 32'(debug_wb_rf_wen), 32'hf);
    tick();

    // 3: write to $zero
    set_m(1'b1, 32'h200, 1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    set_m(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t3_wen1", 32'(wen1), 32'd0);
    chk("t3_wen2", 32'(wen2), 32'd0);
    tick();
    chk("t3_tv", 32'(trace_valid), 32'd1);
    chk("t3_pc", debug_wb_pc, 32'h200);
    chk("t3_rfwen", 32'(debug_wb_rf_wen), 32'd0);
    chk("t3_wnum", 32'(debug_wb_rf_wnum), 32'd0);
    chk("t3_wdata", debug_wb_rf_wdata, 32'hFFFFFFFF);
    tick();

    // 5: slave-only commit
    set_s(1'b1, 32'h300, 1'b1, 5'd9, 32'h99);
    tick();
    set_s(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t5_wen1", 32'(wen1), 32'd0);
    chk("t5_wen2", 32'(wen2), 32'd1);
    chk("t5_wa2", 32'(wa2), 32'd9);
    chk("t5_wd2", wd2, 32'h99);
    tick();
    chk("t5_tv", 32'(trace_valid), 32'd1);
    chk("t5_pc", debug_wb_pc, 32'h300);
    chk("t5_wnum", 32'(debug_wb_rf_wnum), 32'd9);
    tick();
    chk("t5_single", 32'(trace_valid), 32'd0);

    // 4: back-to-back dual commits, upstream holds the slots while not ready
    occ_m = 0; n = 0; tk = 0; traced = 0; saw_drop = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      set_m(1'b1, 32'h1000 + 32'(8 * n), 1'b1, 5'd6, 32'(n));
      set_s(1'b1, 32'h1004 + 32'(8 * n), 1'b1, 5'd7, 32'(n));
      acc = (occ_m <= 6);
      pop = (occ_m > 0);
      chk("t4_ready", 32'(bus.commit_ready), 32'(acc));
      if (!bus.commit_ready) saw_drop = 1'b1;
      tick();
      occ_m = occ_m + (acc ? 2 : 0) - (pop ? 1 : 0);
      if (acc) n++;
      chk("t4_wen1", 32'(wen1), 32'(acc));
      chk("t4_wen2", 32'(wen2), 32'(acc));
      chk("t4_tv", 32'(trace_valid), 32'(pop));
      if (trace_valid) begin
        chk("t4_pc", debug_wb_pc, 32'h1000 + 32'(4 * tk));
        tk++;
        traced++;
      end
    end
    set_m(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_s(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int cyc = 0; cyc < 40 && traced < 2 * n; cyc++) begin
      pop = (occ_m > 0);
      tick();
      if (pop) occ_m--;
      chk("t4_drain_tv", 32'(trace_valid), 32'(pop));
      if (trace_valid) begin
        chk("t4_drain_pc", debug_wb_pc, 32'h1000 + 32'(4 * tk));
        tk++;
        traced++;
      end
    end
    chk("t4_no_loss", 32'(traced), 32'(2 * n));
    chk("t4_ready_dropped", 32'(saw_drop), 32'd1);
    tick();
    chk("t4_empty", 32'(trace_valid), 32'd0);

    // 6: reset with 5 entries queued
    for (int p = 0; p < 4; p++) begin
      set_m(1'b1, 32'h2000 + 32'(8 * p), 1'b1, 5'd1, 32'(p));
      set_s(1'b1, 32'h2004 + 32'(8 * p), 1'b1, 5'd2, 32'(p));
      tick();
    end
    chk("t6_wen1_pre", 32'(wen1), 32'd1);
    set_m(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_s(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    tick();
    chk("t6_tv", 32'(trace_valid), 32'd0);
    chk("t6_wen1", 32'(wen1), 32'd0);
    chk("t6_wen2", 32'(wen2), 32'd0);
    chk("t6_ready_in_rst", 32'(bus.commit_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_ready_rel", 32'(bus.commit_ready), 32'd1);
    tick();
    chk("t6_flushed1", 32'(trace_valid), 32'd0);
    tick();
    chk("t6_flushed2", 32'(trace_valid), 32'd0);
    set_m(1'b1, 32'h500, 1'b1, 5'd1, 32'h55);
    tick();
    set_m(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    chk("t6_post_wen1", 32'(wen1), 32'd1);
    tick();
    chk("t6_post_tv", 32'(trace_valid), 32'd1);
    chk("t6_post_pc", debug_wb_pc, 32'h500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
